// File: rtl/hit_pkg.sv
// Shared widths and decay-pot field positions for the hit intensity generator.
package hit_pkg;
    localparam int VEL_W          = 7;
    localparam int INT_W          = 8;
    localparam int DECAY_STEP_MSB = 9;
    localparam int DECAY_STEP_LSB = 6;
endpackage

// File: rtl/hit_channel.sv
// One instrument: collects the loudest hit of the frame and, on snap, publishes it
// or decays the held level towards zero.
module hit_channel
    import hit_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_snap,
    input  logic [VEL_W-1:0] i_step,
    input  logic             i_hit,
    input  logic [VEL_W-1:0] i_vel,
    output logic [INT_W-1:0] o_intensity
);

    logic             r_pend_valid;
    logic [VEL_W-1:0] r_pend_vel;
    logic [VEL_W-1:0] r_level;
    logic [INT_W-1:0] r_intensity;

    logic             w_eff_valid;
    logic [VEL_W-1:0] w_eff_vel;
    logic [VEL_W-1:0] w_decayed;

    // A hit landing on the snap cycle itself is folded into this snapshot.
    assign w_eff_valid = r_pend_valid || i_hit;
    assign w_eff_vel   = (i_hit && (i_vel > r_pend_vel)) ? i_vel : r_pend_vel;
    assign w_decayed   = (r_level > i_step) ? (r_level - i_step) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_valid <= 1'b0;
            r_pend_vel   <= '0;
            r_level      <= '0;
            r_intensity  <= '0;
        end else if (i_snap) begin
            if (w_eff_valid) begin
                r_level     <= w_eff_vel;
                r_intensity <= {1'b1, w_eff_vel};
            end else begin
                r_level     <= w_decayed;
                r_intensity <= {1'b0, w_decayed};
            end
            r_pend_valid <= 1'b0;
            r_pend_vel   <= '0;
        end else if (i_hit) begin
            r_pend_valid <= 1'b1;
            r_pend_vel   <= w_eff_vel;
        end
    end

    assign o_intensity = r_intensity;

endmodule

// File: rtl/hit_intensity_gen.sv
// Per-instrument hit accumulator with per-frame decay; snapshots once per frame at
// a fixed raster point and holds the result stable for the next frame.
module hit_intensity_gen
    import hit_pkg::*;
#(
    parameter int INSTRUMENT_COUNT = 3,
    parameter int UPDATE_LINE      = 720
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [10:0]                 h_count,
    input  logic [9:0]                  v_count,
    input  logic [INSTRUMENT_COUNT-1:0] hit_valid,
    input  logic [VEL_W-1:0]            hit_velocity   [INSTRUMENT_COUNT-1:0],
    input  logic [9:0]                  decay,
    output logic [INT_W-1:0]            inst_intensity [INSTRUMENT_COUNT-1:0],
    output logic                        frame_tick
);

    localparam logic [9:0] LP_LINE = 10'(UPDATE_LINE);

    logic             w_snap;
    logic [VEL_W-1:0] w_step;
    logic             w_decay_unused;
    logic             r_frame_tick;

    assign w_snap         = (h_count == 11'd0) && (v_count == LP_LINE);
    assign w_step         = {3'b000, decay[DECAY_STEP_MSB:DECAY_STEP_LSB]};
    // Low pot bits are below the step resolution.
    assign w_decay_unused = ^decay[DECAY_STEP_LSB-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= w_snap;
        end
    end

    assign frame_tick = r_frame_tick;

    for (genvar g = 0; g < INSTRUMENT_COUNT; g++) begin : g_ch
        logic w_hit;
        assign w_hit = hit_valid[g] && (hit_velocity[g] != '0);

        hit_channel u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_snap      (w_snap),
            .i_step      (w_step),
            .i_hit       (w_hit),
            .i_vel       (hit_velocity[g]),
            .o_intensity (inst_intensity[g])
        );
    end

endmodule

// File: doc/hit_intensity_gen.md
# hit_intensity_gen

Per-instrument hit accumulator and decay envelope that produces the `inst_intensity` vector consumed by the delay visualiser. It collects drum hits (7-bit velocity per instrument) arriving at any time during a video frame. It snapshots them once per frame at a fixed raster point, and holds the result stable for the following frame. Bit 7 of each output flags "hit this frame"; bits 6:0 carry the hit velocity, or a per-frame decaying level when no hit occurred.

## Interface
Parameters:
- `INSTRUMENT_COUNT`, 3, number of instrument channels.
- `UPDATE_LINE`, 720, `v_count` value at which the snapshot is taken (with `h_count == 0`).

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `h_count`  in  11  raster horizontal position.
- `v_count`  in  10  raster vertical position.
- `hit_valid`  in  INSTRUMENT_COUNT  one-cycle hit strobe per instrument.
- `hit_velocity[INSTRUMENT_COUNT-1:0]`  in  7 each  velocity qualified by `hit_valid[i]`.
- `decay`  in  10  pot value; per-frame decay step = `decay[9:6]` (0..15).
- `inst_intensity[INSTRUMENT_COUNT-1:0]`  out  8 each  `{hit_flag, level[6:0]}`.
- `frame_tick`  out  1  one-cycle pulse, the cycle after a snapshot.

## Operation
- Snapshot condition `snap = (h_count == 0 && v_count == UPDATE_LINE)`, evaluated every cycle.
- Per channel, registers `pend_valid` (1 b), `pend_vel` (7 b), `level` (7 b), and output `inst_intensity` (8 b).
- A hit is `hit_valid[i] && hit_velocity[i] != 0`. Velocity 0 is ignored (note-off).
- Accumulate while not `snap`: on a hit, `pend_valid <= 1` and `pend_vel <= max(pend_vel, hit_velocity[i])`.
- On `snap`, compute an effective pending value that includes any hit on that same cycle: `eff_valid = pend_valid || hit`, `eff_vel = max(pend_vel, hit ? vel : 0)`.
  - If `eff_valid`: `level <= eff_vel`, `inst_intensity <= {1'b1, eff_vel}`.
  - Else: `level <= (level > step) ? level - step : 0`, `inst_intensity <= {1'b0, that new level}`.
  - `pend_valid <= 0` and `pend_vel <= 0`. A hit on the snap cycle is consumed by this snapshot and does not carry over.
- `step = {3'b0, decay[9:6]}`. A step of 0 holds the level indefinitely. All arithmetic is unsigned 7-bit and saturates at 0, never wrapping.
- `frame_tick <= snap`. Snap fires once per frame because (0, UPDATE_LINE) occurs once per frame. If the raster stalls on that point, snap repeats every cycle and each repeat is a full snapshot.
- Channels are independent; `decay` and `snap` are shared.

## Timing
- Reset (async assert, sync release on `clk`): all `pend_*`, `level`, `inst_intensity` = 0; `frame_tick` = 0.
- Latency from hit to output: registered at the first `snap` at or after the hit cycle; visible 1 cycle after that `snap`.
- Output changes only in the cycle after `snap`. It is otherwise stable for the whole frame, including all of line UPDATE_LINE+1, where the consumer samples at `h_count == 0`.
- Reset asserted mid-frame discards pending hits. The first snapshot after release outputs `{0, 0}` unless a hit arrives first.
- Multiple hits on one channel within a frame: the maximum velocity wins. Equal velocities are indistinguishable.

## Structure
- Shared package `hit_pkg`: `VEL_W = 7`, `INT_W = 8`, `DECAY_STEP_MSB = 9`, `DECAY_STEP_LSB = 6`.
- One sub-module, `hit_channel`, is instantiated INSTRUMENT_COUNT times in a generate loop. It holds the pending/level/output registers for one instrument and takes `snap`, `step`, `hit`, `vel`.
- Top level contains the `snap` compare, the `step` extraction, the `frame_tick` register, and the generate loop.

## Test plan
- Single hit: vel 100 on ch0 at line 300 → after next snap, `inst_intensity[0] = 8'hE4`, others `8'h00`; `frame_tick` pulses once.
- Max-of-frame: ch1 vel 40 then 90 then 60 within a frame → `{1, 90}` = `8'hDA`. Following frame, no hits, `decay = 10'h100` (step 4) → `8'h56` (86), then 82, and so on to 0, staying at 0.
- Snap-cycle hit: vel 50 on ch2 exactly at `h_count == 0, v_count == UPDATE_LINE` → `8'hB2` that frame. Next frame, no hits → `{0, 50 - step}`, not a repeated hit flag.
- Zero step and note-off: `decay = 0`, hit 20 → level stays 20 (`8'h14`) for 5 frames. A `hit_valid` with velocity 0 never sets bit 7.
- Async reset mid-frame: hit 70 pending, assert `rst_n = 0` between edges → outputs are 0 immediately. After release with no hits, the next snapshot yields `8'h00`.
- Stability: across line UPDATE_LINE+1, the outputs are unchanged while random hits arrive. The outputs are never modified except in the cycle after `snap`.
